// File: rtl/riscv_imem_bridge.sv
// Instruction-memory bridge between the prefetch buffer and a single-port
// synchronous instruction SRAM. Terminates the req/gnt/rvalid fetch handshake,
// keeps at most one fetch outstanding, adds WAIT_CYCLES of response latency
// and answers out-of-window fetches locally with an all-zero (illegal) word.
module riscv_imem_bridge #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic        oow_reg;
    logic        err_reg;

    logic        oow;
    logic        resp_now;
    logic        slot_free;
    logic        gnt;
    logic [31:0] rdata_src;
    logic        unused_addr_bits;

    // Byte-offset bits never select anything: the SRAM is word addressed.
    assign unused_addr_bits = ^instr_addr_i[1:0];

    // Anything above the SRAM window is out-of-window.
    assign oow = |instr_addr_i[31:ADDR_WIDTH+2];

    // The response cycle is BUSY with the wait counter exhausted; the slot is
    // free again in that same cycle so a follow-on fetch loses no bubble.
    assign resp_now  = (state_reg == BUSY) && (cnt_reg == 3'd0);
    assign slot_free = (state_reg == IDLE) || resp_now;

    // Out-of-window fetches never touch the SRAM, so they ignore mem_ready_i.
    // Gating with rst_n keeps the grant low while reset is held.
    assign gnt = rst_n && instr_req_i && (oow || mem_ready_i) && slot_free;

    assign instr_gnt_o    = gnt;
    assign mem_req_o      = gnt && !oow;
    assign mem_addr_o     = instr_addr_i[ADDR_WIDTH+1:2];
    assign instr_rvalid_o = resp_now;
    assign instr_rdata_o  = !resp_now ? 32'h0000_0000 :
                            oow_reg   ? 32'h0000_0000 : rdata_src;
    assign err_o          = err_reg;

    // Transaction FSM: load the wait counter on grant, count down, and return
    // to IDLE after the response unless a new fetch is granted alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            oow_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            if (gnt) begin
                state_reg <= BUSY;
                cnt_reg   <= WAIT_LOAD;
                oow_reg   <= oow;
            end else if (resp_now) begin
                state_reg <= IDLE;
            end else if ((state_reg == BUSY) && (cnt_reg != 3'd0)) begin
                cnt_reg <= cnt_reg - 3'd1;
            end

            // Sticky error: a new out-of-window grant wins over a clear.
            if (gnt && oow) begin
                err_reg <= 1'b1;
            end else if (err_clr_i) begin
                err_reg <= 1'b0;
            end
        end
    end

    generate
        if (WAIT_CYCLES == 0) begin : g_passthru
            // SRAM data arrives exactly in the response cycle: pass it through.
            assign rdata_src = mem_rdata_i;
        end else begin : g_hold
            logic [31:0] hold_reg;
            logic        cap_reg;

            // SRAM data is only valid one cycle after the read; park it until
            // the delayed response cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= 32'h0000_0000;
                    cap_reg  <= 1'b0;
                end else begin
                    cap_reg <= gnt && !oow;
                    if (cap_reg) begin
                        hold_reg <= mem_rdata_i;
                    end
                end
            end

            assign rdata_src = hold_reg;
        end
    endgenerate

endmodule

// File: tb/tb_riscv_imem_bridge.sv
// Bench for riscv_imem_bridge: three instances (WAIT_CYCLES 0, 2, 3) share
// address/ready/clear/reset stimulus with a per-instance request line. A
// pending-response model checks every cycle; directed steps pin literal values.
module tb_riscv_imem_bridge;

    localparam int N = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        ready;
    logic        clr;
    logic        req       [N];
    logic        gnt       [N];
    logic        rvalid    [N];
    logic [31:0] rdata     [N];
    logic        mreq      [N];
    logic [13:0] maddr     [N];
    logic [31:0] mrdata    [N];
    logic        err       [N];
    logic [31:0] sram_q    [N];
    logic        sram_v    [N];

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // Model state: at most one pending response per instance.
    bit          pend_v    [N];
    int          pend_due  [N];
    logic [31:0] pend_data [N];
    bit          err_m     [N];

    function automatic int wait_of(int i);
        if (i == 0) return 0;
        if (i == 1) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] wordval(logic [13:0] w);
        return 32'hC0DE_0000 | {18'b0, w};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            riscv_imem_bridge #(
                .ADDR_WIDTH (14),
                .WAIT_CYCLES(wait_of(gi))
            ) dut (
                .clk           (clk),
                .rst_n         (rst_n),
                .instr_req_i   (req[gi]),
                .instr_addr_i  (addr),
                .instr_gnt_o   (gnt[gi]),
                .instr_rvalid_o(rvalid[gi]),
                .instr_rdata_o (rdata[gi]),
                .mem_req_o     (mreq[gi]),
                .mem_addr_o    (maddr[gi]),
                .mem_ready_i   (ready),
                .mem_rdata_i   (mrdata[gi]),
                .err_o         (err[gi]),
                .err_clr_i     (clr)
            );

            // Synchronous SRAM: data valid one cycle after an accepted read,
            // junk otherwise so a missed capture shows up.
            always_ff @(posedge clk) begin
                sram_v[gi] <= mreq[gi];
                if (mreq[gi]) sram_q[gi] <= wordval(maddr[gi]);
            end
            assign mrdata[gi] = sram_v[gi] ? sram_q[gi] : 32'hDEAD_BEEF;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Cycle-by-cycle model compare, sampled mid-cycle.
    always @(negedge clk) begin : cmp
        bit          oow;
        bit          resp;
        bit          eg;
        logic [31:0] ed;
        ncyc++;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                pend_v[i] = 1'b0;
                err_m[i]  = 1'b0;
                check($sformatf("i%0d rst gnt", i),    {31'b0, gnt[i]},    32'd0);
                check($sformatf("i%0d rst rvalid", i), {31'b0, rvalid[i]}, 32'd0);
                check($sformatf("i%0d rst mreq", i),   {31'b0, mreq[i]},   32'd0);
                check($sformatf("i%0d rst rdata", i),  rdata[i],           32'd0);
                check($sformatf("i%0d rst err", i),    {31'b0, err[i]},    32'd0);
            end else begin
                oow  = (addr[31:16] != 16'd0);
                resp = pend_v[i] && (pend_due[i] == ncyc);
                eg   = req[i] && (oow || ready) && (!pend_v[i] || resp);
                ed   = oow ? 32'd0 : wordval(addr[15:2]);
                check($sformatf("i%0d gnt", i),    {31'b0, gnt[i]},    {31'b0, eg});
                check($sformatf("i%0d mreq", i),   {31'b0, mreq[i]},   {31'b0, eg && !oow});
                check($sformatf("i%0d maddr", i),  {18'b0, maddr[i]},  {18'b0, addr[15:2]});
                check($sformatf("i%0d rvalid", i), {31'b0, rvalid[i]}, {31'b0, resp});
                if (resp) check($sformatf("i%0d rdata", i), rdata[i], pend_data[i]);
                check($sformatf("i%0d err", i),    {31'b0, err[i]},    {31'b0, err_m[i]});
                if (resp) pend_v[i] = 1'b0;
                if (eg) begin
                    pend_v[i]    = 1'b1;
                    pend_due[i]  = ncyc + 1 + wait_of(i);
                    pend_data[i] = ed;
                end
                if (eg && oow) err_m[i] = 1'b1;
                else if (clr)  err_m[i] = 1'b0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 32'd0;
        ready = 1'b1;
        clr   = 1'b0;
        for (int i = 0; i < N; i++) req[i] = 1'b0;
        nxt(); nxt();
        smp();
        for (int i = 0; i < N; i++) begin
            check("reset rvalid", {31'b0, rvalid[i]}, 32'd0);
            check("reset err",    {31'b0, err[i]},    32'd0);
        end
        nxt(); rst_n = 1'b1;
        nxt();

        // Back-to-back fetches, WAIT_CYCLES=0.
        req[0] = 1'b1; addr = 32'h0;
        smp(); check("t1 gnt0", {31'b0, gnt[0]}, 32'd1); check("t1 maddr0", {18'b0, maddr[0]}, 32'd0);
        nxt(); addr = 32'h4;
        smp(); check("t1 gnt1", {31'b0, gnt[0]}, 32'd1); check("t1 maddr1", {18'b0, maddr[0]}, 32'd1);
        check("t1 rdata0", rdata[0], 32'hC0DE_0000);
        nxt(); addr = 32'h8;
        smp(); check("t1 maddr2", {18'b0, maddr[0]}, 32'd2); check("t1 rdata1", rdata[0], 32'hC0DE_0001);
        nxt(); req[0] = 1'b0;
        smp(); check("t1 rv2", {31'b0, rvalid[0]}, 32'd1); check("t1 rdata2", rdata[0], 32'hC0DE_0002);
        nxt();

        // WAIT_CYCLES=2 latency and held follow-on request.
        req[1] = 1'b1; addr = 32'h100;
        smp(); check("t2 gnt", {31'b0, gnt[1]}, 32'd1); check("t2 maddr", {18'b0, maddr[1]}, 32'h40);
        nxt(); addr = 32'h104;
        smp(); check("t2 early gnt", {31'b0, gnt[1]}, 32'd0);
        nxt();
        smp(); check("t2 early rv", {31'b0, rvalid[1]}, 32'd0);
        nxt();
        smp(); check("t2 rv", {31'b0, rvalid[1]}, 32'd1); check("t2 rdata", rdata[1], 32'hC0DE_0040);
        check("t2 gnt2", {31'b0, gnt[1]}, 32'd1);
        nxt(); req[1] = 1'b0;
        nxt(); nxt();
        smp(); check("t2 rdata2", rdata[1], 32'hC0DE_0041);
        nxt();

        // SRAM stall with address change while pending.
        ready = 1'b0; req[0] = 1'b1; addr = 32'h20;
        smp(); check("t3 stall gnt", {31'b0, gnt[0]}, 32'd0); check("t3 stall mreq", {31'b0, mreq[0]}, 32'd0);
        nxt();
        nxt(); addr = 32'h80;
        smp(); check("t3 stall gnt2", {31'b0, gnt[0]}, 32'd0);
        nxt();
        nxt(); ready = 1'b1;
        smp(); check("t3 gnt", {31'b0, gnt[0]}, 32'd1); check("t3 maddr", {18'b0, maddr[0]}, 32'h20);
        nxt(); req[0] = 1'b0;
        smp(); check("t3 rdata", rdata[0], 32'hC0DE_0020);
        nxt();

        // Out-of-window fetch and sticky error.
        ready = 1'b0; req[0] = 1'b1; addr = 32'h0001_0000;
        smp(); check("t4 gnt", {31'b0, gnt[0]}, 32'd1); check("t4 mreq", {31'b0, mreq[0]}, 32'd0);
        nxt(); req[0] = 1'b0;
        smp(); check("t4 rv", {31'b0, rvalid[0]}, 32'd1); check("t4 rdata", rdata[0], 32'd0);
        check("t4 err", {31'b0, err[0]}, 32'd1);
        nxt(); clr = 1'b1;
        nxt(); clr = 1'b0;
        smp(); check("t4 cleared", {31'b0, err[0]}, 32'd0);
        nxt(); req[0] = 1'b1; clr = 1'b1;
        nxt(); req[0] = 1'b0; clr = 1'b0;
        smp(); check("t4 set wins", {31'b0, err[0]}, 32'd1);
        nxt(); clr = 1'b1;
        nxt(); clr = 1'b0;
        req[1] = 1'b1; addr = 32'h8000_0004;
        smp(); check("t4 oow w2 gnt", {31'b0, gnt[1]}, 32'd1);
        nxt(); req[1] = 1'b0;
        nxt();
        nxt();
        smp(); check("t4 oow w2 rv", {31'b0, rvalid[1]}, 32'd1); check("t4 oow w2 rdata", rdata[1], 32'd0);
        nxt();

        // Prefetch-buffer abort pattern: both responses delivered in order.
        ready = 1'b1; req[1] = 1'b1; addr = 32'h10;
        smp(); check("t5 gnt", {31'b0, gnt[1]}, 32'd1);
        nxt(); addr = 32'h200;
        nxt();
        nxt();
        smp(); check("t5 rdata1", rdata[1], 32'hC0DE_0004); check("t5 gnt2", {31'b0, gnt[1]}, 32'd1);
        nxt(); req[1] = 1'b0;
        nxt(); nxt();
        smp(); check("t5 rdata2", rdata[1], 32'hC0DE_0080);
        nxt();

        // Reset mid-transaction with WAIT_CYCLES=3.
        req[2] = 1'b1; addr = 32'h40;
        smp(); check("t6 gnt", {31'b0, gnt[2]}, 32'd1);
        nxt(); req[2] = 1'b0; rst_n = 1'b0;
        #1;
        check("t6 imm rvalid", {31'b0, rvalid[2]}, 32'd0);
        check("t6 imm rdata",  rdata[2], 32'd0);
        check("t6 imm mreq",   {31'b0, mreq[2]}, 32'd0);
        nxt(); rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            smp(); check("t6 no rvalid", {31'b0, rvalid[2]}, 32'd0);
            nxt();
        end
        req[2] = 1'b1; addr = 32'h8;
        smp(); check("t6 regnt", {31'b0, gnt[2]}, 32'd1);
        nxt(); req[2] = 1'b0;
        nxt(); nxt(); nxt();
        smp(); check("t6 rv", {31'b0, rvalid[2]}, 32'd1); check("t6 rdata", rdata[2], 32'hC0DE_0002);
        nxt(); nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
